// File: rtl/forest_vote.sv
// forest_vote: collects NUM_TREES class votes from a random-forest's trees,
// picks the majority class among sunny/rainy/snowy and holds the prediction
// until the consumer takes it.
// Optional feature macro: FOREST_PREV_TIE_EN -- ties prefer the class of the
// previous prediction when it is among the tied classes.
module forest_vote #(
  parameter int NUM_TREES = 5
) (
  input  logic       CLOCK_50,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [2:0] in_class,
  output logic       in_ready,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [2:0] out_class,
  output logic [3:0] out_votes
);

  localparam logic [3:0] LAST_VOTE = 4'(NUM_TREES);

  localparam logic [2:0] CLS_SUNNY   = 3'b000;
  localparam logic [2:0] CLS_RAINY   = 3'b001;
  localparam logic [2:0] CLS_SNOWY   = 3'b110;
  localparam logic [2:0] CLS_UNKNOWN = 3'b111;

  typedef enum logic [1:0] {COLLECT, DECIDE, HOLD} state_t;

  state_t     state;
  logic [3:0] cnt_sunny;
  logic [3:0] cnt_rainy;
  logic [3:0] cnt_snowy;
  logic [3:0] cnt_unknown;
  logic [3:0] cnt_total;
  logic [2:0] win_class;
  logic [3:0] win_votes;
`ifdef FOREST_PREV_TIE_EN
  logic [2:0] prev_class;
`endif

  // Votes are only taken while collecting; state is a register so this is glitch-free.
  assign in_ready = (state == COLLECT);

  // Winner selection: strict-greater compares give sunny > rainy > snowy on ties.
  always_comb begin
    win_class = CLS_SUNNY;
    win_votes = cnt_sunny;
    if (cnt_rainy > win_votes) begin
      win_class = CLS_RAINY;
      win_votes = cnt_rainy;
    end
    if (cnt_snowy > win_votes) begin
      win_class = CLS_SNOWY;
      win_votes = cnt_snowy;
    end
`ifdef FOREST_PREV_TIE_EN
    // A tied previous winner keeps its title; the vote count is the same either way.
    if ((prev_class == CLS_SUNNY && cnt_sunny == win_votes) ||
        (prev_class == CLS_RAINY && cnt_rainy == win_votes) ||
        (prev_class == CLS_SNOWY && cnt_snowy == win_votes)) begin
      win_class = prev_class;
    end
`endif
    // No weather votes at all: report unknown with zero votes.
    if (win_votes == 4'd0) begin
      win_class = CLS_UNKNOWN;
    end
  end

  // Control FSM with vote counters and registered prediction outputs.
  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      state       <= COLLECT;
      cnt_sunny   <= 4'd0;
      cnt_rainy   <= 4'd0;
      cnt_snowy   <= 4'd0;
      cnt_unknown <= 4'd0;
      cnt_total   <= 4'd0;
      out_valid   <= 1'b0;
      out_class   <= CLS_UNKNOWN;
      out_votes   <= 4'd0;
`ifdef FOREST_PREV_TIE_EN
      prev_class  <= CLS_UNKNOWN;
`endif
    end else begin
      case (state)
        COLLECT: begin
          if (in_valid) begin
            case (in_class)
              CLS_SUNNY: cnt_sunny   <= cnt_sunny + 4'd1;
              CLS_RAINY: cnt_rainy   <= cnt_rainy + 4'd1;
              CLS_SNOWY: cnt_snowy   <= cnt_snowy + 4'd1;
              default:   cnt_unknown <= cnt_unknown + 4'd1;
            endcase
            cnt_total <= cnt_total + 4'd1;
            if (cnt_total == LAST_VOTE - 4'd1) begin
              state <= DECIDE;
            end
          end
        end
        DECIDE: begin
          out_class <= win_class;
          out_votes <= win_votes;
          state     <= HOLD;
        end
        HOLD: begin
          // The prediction becomes visible one cycle after it is registered.
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid   <= 1'b0;
            cnt_sunny   <= 4'd0;
            cnt_rainy   <= 4'd0;
            cnt_snowy   <= 4'd0;
            cnt_unknown <= 4'd0;
            cnt_total   <= 4'd0;
            state       <= COLLECT;
`ifdef FOREST_PREV_TIE_EN
            prev_class  <= out_class;
`endif
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_forest_vote.sv
// Self-checking bench for forest_vote (NUM_TREES=5) using an expected-result queue.
module tb_forest_vote;
  localparam int NT = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [2:0] in_class;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_class;
  logic [3:0] out_votes;

  int errors = 0;
  int checks = 0;
  logic [6:0] exp_q[$];
  logic [2:0] prev_model = 3'b111;
  logic [6:0] last_result;

  always #5 clk = ~clk;

  forest_vote #(.NUM_TREES(NT)) dut (
    .CLOCK_50 (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_class (in_class),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_class(out_class),
    .out_votes(out_votes)
  );

  function automatic logic [14:0] pack5(input logic [2:0] a, input logic [2:0] b,
                                        input logic [2:0] c, input logic [2:0] d,
                                        input logic [2:0] e);
    return {e, d, c, b, a};
  endfunction

  // Reference: count the weather votes and pick the winner from scratch.
  function automatic logic [6:0] model(input logic [14:0] v, input logic [2:0] prev);
    int s = 0;
    int r = 0;
    int w = 0;
    int best;
    logic [2:0] cls;
    logic [2:0] one;
    for (int i = 0; i < NT; i++) begin
      one = v[i*3 +: 3];
      if (one == 3'b000) s++;
      else if (one == 3'b001) r++;
      else if (one == 3'b110) w++;
    end
    best = s;
    if (r > best) best = r;
    if (w > best) best = w;
    if (best == 0) return {3'b111, 4'd0};
    if (s == best) cls = 3'b000;
    else if (r == best) cls = 3'b001;
    else cls = 3'b110;
`ifdef FOREST_PREV_TIE_EN
    if ((prev == 3'b000 && s == best) || (prev == 3'b001 && r == best) ||
        (prev == 3'b110 && w == best)) cls = prev;
`else
    if (prev == 3'b010) cls = cls;  // prev has no effect without the tie feature
`endif
    return {cls, 4'(best)};
  endfunction

  // Drive NT votes, one every (gap+1) cycles, and queue the expected prediction.
  task automatic send_votes(input string name, input logic [14:0] v, input int gap);
    exp_q.push_back(model(v, prev_model));
    for (int i = 0; i < NT; i++) begin
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        in_valid = 1'b0;
      end
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1)
        $display("FAIL %s in_ready before vote %0d: got %b want 1", name, i, in_ready);
      in_valid = 1'b1;
      in_class = v[i*3 +: 3];
      @(posedge clk);
    end
  endtask

  // Wait (bounded) for out_valid while junk votes are offered; check latency and result.
  task automatic get_result(input string name);
    int lat = 0;
    bit seen = 0;
    logic [6:0] exp;
    while (lat < 20 && !seen) begin
      @(posedge clk);
      lat++;
      #1;
      seen = out_valid;
      if (!seen) begin
        checks++;
        if (in_ready !== 1'b0)
          $display("FAIL %s in_ready while deciding: got %b want 0", name, in_ready);
      end
      in_valid = 1'b1;
      in_class = 3'($urandom_range(0, 7));
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s out_valid timeout: got 0 want 1 within 20 cycles", name);
    end
    checks++;
    if (lat !== 2) begin
      errors++;
      $display("FAIL %s latency: got %0d want 2 edges", name, lat);
    end
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard empty: got result with nothing expected", name);
      exp = 7'h7f;
    end else begin
      exp = exp_q.pop_front();
    end
    checks++;
    if (out_class !== exp[6:4]) begin
      errors++;
      $display("FAIL %s out_class: got %b want %b", name, out_class, exp[6:4]);
    end
    checks++;
    if (out_votes !== exp[3:0]) begin
      errors++;
      $display("FAIL %s out_votes: got %0d want %0d", name, out_votes, exp[3:0]);
    end
    last_result = exp;
    $display("%s: class=%b votes=%0d latency=%0d", name, out_class, out_votes, lat);
  endtask

  // Take the prediction with in_valid still high; the vote must not be accepted.
  task automatic handshake(input string name);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s out_valid after handshake: got %b want 0", name, out_valid);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s in_ready after handshake: got %b want 1", name, in_ready);
    end
    prev_model = last_result[6:4];
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if (out_valid !== 1'b0 || out_class !== 3'b111 || out_votes !== 4'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s reset outputs: got valid=%b class=%b votes=%0d ready=%b want 0 111 0 1",
               name, out_valid, out_class, out_votes, in_ready);
    end
  endtask

  task automatic test_reset();
    #1;
    check_reset_outputs("test_reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_outputs("test_reset_release");
    $display("test_reset: done");
  endtask

  task automatic test_majority();
    send_votes("test_majority", pack5(3'b001, 3'b001, 3'b000, 3'b110, 3'b001), 0);
    get_result("test_majority");
    handshake("test_majority");
  endtask

  task automatic test_tie();
    send_votes("test_tie", pack5(3'b000, 3'b001, 3'b111, 3'b111, 3'b010), 0);
    get_result("test_tie");
    handshake("test_tie");
  endtask

  task automatic test_all_unknown();
    send_votes("test_all_unknown", pack5(3'b111, 3'b010, 3'b011, 3'b100, 3'b101), 0);
    get_result("test_all_unknown");
    handshake("test_all_unknown");
  endtask

  task automatic test_hold_stall();
    send_votes("test_hold_stall", pack5(3'b110, 3'b000, 3'b000, 3'b001, 3'b110), 0);
    get_result("test_hold_stall");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_class = 3'($urandom_range(0, 7));
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_class !== last_result[6:4] ||
          out_votes !== last_result[3:0] || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL test_hold_stall cycle %0d: got valid=%b class=%b votes=%0d ready=%b want 1 %b %0d 0",
                 i, out_valid, out_class, out_votes, in_ready, last_result[6:4], last_result[3:0]);
      end
    end
    handshake("test_hold_stall");
    send_votes("test_hold_fresh", pack5(3'b110, 3'b110, 3'b000, 3'b001, 3'b110), 0);
    get_result("test_hold_fresh");
    handshake("test_hold_fresh");
  endtask

  task automatic test_gapped();
    send_votes("test_gapped", pack5(3'b001, 3'b001, 3'b000, 3'b110, 3'b001), 2);
    get_result("test_gapped");
    handshake("test_gapped");
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_class = 3'b000;
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_reset_outputs("test_reset_mid_collect");
    @(negedge clk);
    rst = 1'b0;
    prev_model = 3'b111;
    send_votes("test_reset_mid", pack5(3'b110, 3'b110, 3'b110, 3'b110, 3'b110), 0);
    get_result("test_reset_mid");
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_reset_outputs("test_reset_hold");
    @(negedge clk);
    rst = 1'b0;
    prev_model = 3'b111;
    send_votes("test_after_reset", pack5(3'b000, 3'b001, 3'b001, 3'b000, 3'b000), 0);
    get_result("test_after_reset");
    handshake("test_after_reset");
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_class  = 3'b000;
    out_ready = 1'b0;
    test_reset();
    test_majority();
    test_tie();
    test_all_unknown();
    test_hold_stall();
    test_gapped();
    test_reset_mid();
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard leftover: got %0d entries want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/forest_vote.md
FOREST_VOTE -- requirements
Module: forest_vote

Interface
REQ-001 SHALL have parameter NUM_TREES, default 5, meaning the number of tree votes per prediction (legal range 1..15).
REQ-002 SHALL have port CLOCK_50  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port in_valid  input  1  a tree class vote is presented.
REQ-005 SHALL have port in_class  input  3  the vote: 000 sunny, 001 rainy, 110 snowy, 111 unknown.
REQ-006 SHALL have port in_ready  output  1  the block can accept a vote this cycle.
REQ-007 SHALL have port out_valid  output  1  a forest prediction is held on out_class/out_votes.
REQ-008 SHALL have port out_ready  input  1  the consumer takes the prediction.
REQ-009 SHALL have port out_class  output  3  the winning class, using the same encoding as in_class.
REQ-010 SHALL have port out_votes  output  4  the vote count of the winning class (0 if out_class=111).

Function
REQ-011 SHALL implement a three-state FSM: COLLECT, DECIDE, HOLD.
REQ-012 In COLLECT, SHALL drive in_ready=1, and SHALL accept a vote on each edge with in_valid=1.
REQ-013 On each accepted vote, SHALL increment exactly one 4-bit counter: sunny, rainy, snowy or unknown.
REQ-014 in_class codes 010..101 SHALL be counted as unknown.
REQ-015 SHALL move COLLECT->DECIDE on the edge that accepts vote number NUM_TREES.
REQ-016 In DECIDE and HOLD, SHALL drive in_ready=0; votes presented then SHALL be ignored and not counted.
REQ-017 DECIDE SHALL last exactly one cycle, register out_class/out_votes, then go to HOLD.
REQ-018 out_valid SHALL rise on the second rising edge after the edge that accepted the final vote.
REQ-019 Winner SHALL be the class with the highest count among sunny, rainy and snowy; unknown votes never win.
REQ-020 If the sunny, rainy and snowy counts are all zero, SHALL output out_class=111 and out_votes=0.
REQ-021 Ties (macro absent) SHALL resolve by priority: sunny > rainy > snowy.
REQ-022 In HOLD, SHALL keep out_valid=1 and out_class/out_votes stable until an edge with out_ready=1.
REQ-023 On that edge, SHALL clear out_valid and all counters and return to COLLECT; in_ready=1 in the next cycle.
REQ-024 in_valid and out_ready asserted together in HOLD: SHALL complete the output handshake only; the vote is not accepted.
REQ-025 Counters SHALL never wrap; NUM_TREES<=15 guarantees this.

Reset
REQ-026 While rst=1, SHALL force: state=COLLECT, all counters=0, out_valid=0, out_class=111, out_votes=0, in_ready=1.
REQ-027 rst asserted mid-collection or during HOLD SHALL discard partial votes and any pending prediction.
REQ-028 The previous-winner register SHALL reset to 111.

Configuration
REQ-029 Macro FOREST_PREV_TIE_EN, when defined: on a tie, SHALL select the previous prediction's class if it is among the tied classes, else fall back to REQ-021 priority.
REQ-030 When FOREST_PREV_TIE_EN is defined, SHALL update the previous-winner register on each HOLD->COLLECT handshake.
REQ-031 When FOREST_PREV_TIE_EN is undefined, SHALL use only REQ-021 priority and SHALL not implement the previous-winner register.

Verification
REQ-032 NUM_TREES=5; votes 001,001,000,110,001 back-to-back -> out_class=001, out_votes=3, out_valid rises 2 edges after 5th vote.
REQ-033 Votes 000,001,111,111,010 -> tie 1:1, out_class=000, out_votes=1 (macro undefined); with FOREST_PREV_TIE_EN and previous winner 001 -> out_class=001.
REQ-034 Votes 111,111,111,111,111 -> out_class=111, out_votes=0.
REQ-035 out_ready=0 for 10 cycles in HOLD with in_valid=1 throughout -> outputs stable, in_ready=0, no counters change; out_ready=1 -> return to COLLECT, next 5 votes form a fresh prediction.
REQ-036 rst pulsed after 3 votes accepted, then 5 votes 110 -> out_class=110, out_votes=5 (earlier votes discarded).
REQ-037 in_valid gapped (vote every 3rd cycle) -> same result as back-to-back; only in_valid=1 cycles counted.
